// File: rtl/loader_pkg.sv
// Shared types for the boot-time instruction loader: FSM encoding and word geometry.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // Byte address of payload word idx relative to base; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte stream valid/ready channel feeding the loader (UART RX or testbench is the master).
interface instr_loader_if;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);

endinterface

// File: rtl/instr_loader_word_assembler.sv
// Big-endian byte-to-word packer; word/word_done are combinational on the 4th accepted byte,
// so the consumer captures the word on the same edge that accepts its last byte.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        valid,
  input  logic        ready,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_done
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [23:0] shift_q;
  logic [1:0]  byte_cnt;
  logic        accept;

  assign accept    = valid & ready;
  assign word      = {shift_q, data};
  assign word_done = accept && (byte_cnt == LAST_BYTE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q  <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      shift_q  <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      shift_q  <= {shift_q[15:0], data};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a framed program (N, N words, XOR checksum) into instruction memory while holding the CPU
// in reset; DONE/ERR entered on the edge accepting the last checksum byte, byte_ready low outside HDR/LOAD/CHK.
module instr_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  instr_loader_if.slave       bus,
  output logic                initialize,
  output logic [31:0]         instruction_initialize_data,
  output logic [31:0]         instruction_initialize_address,
  output logic                cpu_rst,
  output logic                done,
  output logic                error,
  output logic [15:0]         words_loaded
);

  state_t      state;
  logic        byte_ready_q;
  logic [31:0] csum;
  logic [15:0] n_words;
  logic [31:0] word;
  logic        word_done;
  logic        load_go;

  assign bus.byte_ready = byte_ready_q;
  assign load_go = start && (state == IDLE || state == DONE || state == ERR);

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (load_go),
    .valid     (bus.byte_valid),
    .ready     (byte_ready_q),
    .data      (bus.byte_data),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                          <= IDLE;
      byte_ready_q                   <= 1'b0;
      initialize                     <= 1'b0;
      cpu_rst                        <= 1'b1;
      done                           <= 1'b0;
      error                          <= 1'b0;
      instruction_initialize_address <= BASE_ADDR;
      instruction_initialize_data    <= '0;
      words_loaded                   <= '0;
      csum                           <= '0;
      n_words                        <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= HDR;
            byte_ready_q <= 1'b1;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            csum         <= '0;
          end
        end
        HDR: begin
          if (word_done) begin
            if (word > 32'(MAX_WORDS)) begin
              state        <= ERR;
              byte_ready_q <= 1'b0;
              error        <= 1'b1;
            end else begin
              // Start writing from a clean (BASE_ADDR, 0) pair; N == 0 keeps it through CHK.
              n_words                        <= word[15:0];
              instruction_initialize_address <= BASE_ADDR;
              instruction_initialize_data    <= '0;
              initialize                     <= 1'b1;
              state                          <= (word == '0) ? CHK : LOAD;
            end
          end
        end
        LOAD: begin
          if (word_done) begin
            instruction_initialize_data    <= word;
            instruction_initialize_address <= word_addr(BASE_ADDR, words_loaded);
            words_loaded                   <= words_loaded + 16'd1;
            csum                           <= csum ^ word;
            if (words_loaded + 16'd1 == n_words) state <= CHK;
          end
        end
        CHK: begin
          if (word_done) begin
            initialize   <= 1'b0;
            byte_ready_q <= 1'b0;
            if (word == csum) begin
              state   <= DONE;
              cpu_rst <= 1'b0;
              done    <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboarded bench: stimulus queues expected load outcomes, a monitor checks them on done/error.
module tb_instr_loader;

  localparam int MAX_WORDS = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        initialize, cpu_rst, done, error;
  logic [31:0] init_data, init_addr;
  logic [15:0] words_loaded;

  instr_loader_if bus ();

  instr_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(MAX_WORDS)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .start                          (start),
    .bus                            (bus.slave),
    .initialize                     (initialize),
    .instruction_initialize_data    (init_data),
    .instruction_initialize_address (init_addr),
    .cpu_rst                        (cpu_rst),
    .done                           (done),
    .error                          (error),
    .words_loaded                   (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        done;
    logic        error;
    logic [15:0] wl;
    int          nmem;
    logic [31:0] a0, d0, a1, d1;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total = 0;
  logic [31:0] mem [logic [31:0]];
  logic        fin_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hxxxx_xxxx;
  endfunction

  // Instruction memory model: a write happens every cycle initialize is high.
  always @(negedge clk) if (initialize) mem[init_addr] = init_data;

  always @(negedge clk) begin
    exp_t e;
    if ((done | error) && !fin_q) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_completion: got done=%0b error=%0b expected none", done, error);
      end else begin
        e = sb.pop_front();
        check({e.name, "_done"}, done, e.done);
        check({e.name, "_error"}, error, e.error);
        check({e.name, "_cpu_rst"}, cpu_rst, !e.done);
        check({e.name, "_initialize"}, initialize, 0);
        check({e.name, "_words_loaded"}, words_loaded, e.wl);
        check({e.name, "_exclusive"}, done & error, 0);
        if (e.nmem > 0) check({e.name, "_mem_a0"}, mem_rd(e.a0), e.d0);
        if (e.nmem > 1) check({e.name, "_mem_a1"}, mem_rd(e.a1), e.d1);
      end
    end
    fin_q = done | error;
  end

  task automatic push_exp(input string name, input logic d, input logic er, input logic [15:0] wl,
                          input int nmem, input logic [31:0] a0, input logic [31:0] d0,
                          input logic [31:0] a1, input logic [31:0] d1);
    exp_t e;
    e.name = name; e.done = d; e.error = er; e.wl = wl; e.nmem = nmem;
    e.a0 = a0; e.d0 = d0; e.a1 = a1; e.d1 = d1;
    sb.push_back(e);
  endtask

  // All drive tasks begin and end 1 time unit after a rising edge.
  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    while (!bus.byte_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.byte_ready) begin
      total++;
      $display("FAIL byte_timeout: got byte_ready=0 expected 1 within 200 cycles");
    end else begin
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(w[31 - 8*i -: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic send_nominal(input int maxgap, input logic [31:0] cs);
    send_word(32'd2, maxgap);
    send_word(32'h2008_0005, maxgap);
    send_word(32'h2009_000A, maxgap);
    send_word(cs, maxgap);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drained"}, sb.size(), 0);
  endtask

  task automatic idle_valid_probe(input string name, input logic [15:0] wl);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check({name, "_byte_ready"}, bus.byte_ready, 0);
    check({name, "_wl_stable"}, words_loaded, wl);
    bus.byte_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    #12;
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_initialize", initialize, 0);
    check("rst_byte_ready", bus.byte_ready, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_addr", init_addr, 32'h0);
    check("rst_data", init_data, 32'h0);
    check("rst_words_loaded", words_loaded, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_valid_probe("idle", 16'd0);

    // Nominal two-word load.
    mem.delete();
    pulse_start();
    check("nom_hdr_ready", bus.byte_ready, 1);
    check("nom_cpu_rst_held", cpu_rst, 1);
    push_exp("nominal", 1, 0, 2, 2, 32'h0, 32'h2008_0005, 32'h4, 32'h2009_000A);
    send_nominal(0, 32'h0001_000F);
    check("nom_done_latency", done, 1);
    wait_drain("nominal");
    idle_valid_probe("done_state", 16'd2);

    // Bad checksum, restarted from DONE.
    mem.delete();
    pulse_start();
    check("bad_cpu_rst_reassert", cpu_rst, 1);
    check("bad_done_cleared", done, 0);
    push_exp("badcsum", 0, 1, 2, 2, 32'h0, 32'h2008_0005, 32'h4, 32'h2009_000A);
    send_nominal(0, 32'h0000_0000);
    wait_drain("badcsum");

    // Oversize count.
    pulse_start();
    push_exp("oversize", 0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    send_word(32'(MAX_WORDS + 1), 0);
    check("oversize_err_latency", error, 1);
    wait_drain("oversize");
    idle_valid_probe("err_state", 16'd0);

    // Handshake stress with random valid gaps.
    mem.delete();
    pulse_start();
    push_exp("stress", 1, 0, 2, 2, 32'h0, 32'h2008_0005, 32'h4, 32'h2009_000A);
    send_nominal(5, 32'h0001_000F);
    wait_drain("stress");

    // Reset in the middle of LOAD, then a full reload.
    mem.delete();
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'h2008_0005, 0);
    send_byte(8'h20, 0);
    send_byte(8'h09, 0);
    check("midload_wl_before", words_loaded, 1);
    rst = 1'b0;
    #2;
    check("midrst_initialize", initialize, 0);
    check("midrst_cpu_rst", cpu_rst, 1);
    check("midrst_words_loaded", words_loaded, 0);
    check("midrst_byte_ready", bus.byte_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mem.delete();
    pulse_start();
    push_exp("after_rst", 1, 0, 2, 2, 32'h0, 32'h2008_0005, 32'h4, 32'h2009_000A);
    send_nominal(0, 32'h0001_000F);
    wait_drain("after_rst");

    // Reload from DONE with a single word.
    mem.delete();
    pulse_start();
    push_exp("reload", 1, 0, 1, 1, 32'h0, 32'h0800_0000, 32'h0, 32'h0);
    send_word(32'd1, 0);
    check("reload_cpu_rst_during", cpu_rst, 1);
    check("reload_initialize_during", initialize, 1);
    send_word(32'h0800_0000, 0);
    send_word(32'h0800_0000, 0);
    wait_drain("reload");

    // Empty program: word 0 is overwritten with zero during CHK.
    mem.delete();
    pulse_start();
    push_exp("empty", 1, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0);
    send_word(32'd0, 0);
    check("empty_chk_initialize", initialize, 1);
    check("empty_chk_addr", init_addr, 32'h0);
    check("empty_chk_data", init_data, 32'h0);
    send_word(32'd0, 0);
    wait_drain("empty");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
